// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the A, B and mem handshake buses around the memory arbiter.
// slave is the arbiter's view; master is the view of the masters plus memory.
`ifndef PADDR
`define PADDR 22
`endif
`ifndef WORD
`define WORD 36
`endif

interface mem_arb_if;
    logic [`PADDR-1:0] a_addr;
    logic [`WORD-1:0]  a_write_data;
    logic              a_write;
    logic              a_read;
    logic [`WORD-1:0]  a_read_data;
    logic              a_write_ack;
    logic              a_read_ack;
    logic              a_nxm;
    logic [`PADDR-1:0] b_addr;
    logic [`WORD-1:0]  b_write_data;
    logic              b_write;
    logic              b_read;
    logic [`WORD-1:0]  b_read_data;
    logic              b_write_ack;
    logic              b_read_ack;
    logic              b_nxm;
    logic [`PADDR-1:0] mem_addr;
    logic [`WORD-1:0]  mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [`WORD-1:0]  mem_read_data;
    logic              mem_write_ack;
    logic              mem_read_ack;
    logic              mem_nxm;

    modport slave (
        input  a_addr, a_write_data, a_write, a_read,
        output a_read_data, a_write_ack, a_read_ack, a_nxm,
        input  b_addr, b_write_data, b_write, b_read,
        output b_read_data, b_write_ack, b_read_ack, b_nxm,
        output mem_addr, mem_write_data, mem_write, mem_read,
        input  mem_read_data, mem_write_ack, mem_read_ack, mem_nxm
    );

    modport master (
        output a_addr, a_write_data, a_write, a_read,
        input  a_read_data, a_write_ack, a_read_ack, a_nxm,
        output b_addr, b_write_data, b_write, b_read,
        input  b_read_data, b_write_ack, b_read_ack, b_nxm,
        input  mem_addr, mem_write_data, mem_write, mem_read,
        output mem_read_data, mem_write_ack, mem_read_ack, mem_nxm
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: serialises A/B requests onto the single mem port, routes ack/nxm back and times out silent memory.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise A has fixed priority over B.
`ifndef PADDR
`define PADDR 22
`endif
`ifndef WORD
`define WORD 36
`endif

module mem_arb #(
    parameter int TIMEOUT = 64
) (
    input logic      clk,
    input logic      reset,
    mem_arb_if.slave bus
);
    localparam int CW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic          grant;
    logic [CW-1:0] cnt;
    logic          a_req, b_req, win_b, resp, tmo, ga, gb;

    assign a_req = bus.a_read | bus.a_write;
    assign b_req = bus.b_read | bus.b_write;
    assign resp  = bus.mem_read_ack | bus.mem_write_ack | bus.mem_nxm;
    // a real mem response in the expiry cycle takes precedence over the arbiter's own nxm
    assign tmo   = (TIMEOUT != 0) && state == BUSY && !resp && (32'(cnt) == TIMEOUT - 1);

`ifdef MEMARB_RR_EN
    logic last_b;
    assign win_b = b_req & (~a_req | ~last_b);
    always_ff @(posedge clk) begin
        if (reset)
            last_b <= 1'b1;
        else if (state == IDLE && (a_req | b_req))
            last_b <= win_b;
    end
`else
    assign win_b = ~a_req;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? ((a_req | b_req) ? BUSY : IDLE) :
                   state == BUSY ? ((resp | tmo) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant              <= 1'b0;
            cnt                <= '0;
            bus.mem_addr       <= '0;
            bus.mem_write_data <= '0;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b0;
        end else begin
            cnt <= state == BUSY ? cnt + 1'b1 : '0;
            if (state == IDLE && (a_req | b_req)) begin
                grant              <= win_b;
                bus.mem_addr       <= win_b ? bus.b_addr : bus.a_addr;
                bus.mem_write_data <= win_b ? bus.b_write_data : bus.a_write_data;
                bus.mem_write      <= win_b ? bus.b_write : bus.a_write;
                bus.mem_read       <= win_b ? bus.b_read & ~bus.b_write : bus.a_read & ~bus.a_write;
            end else if (state == BUSY && (resp | tmo)) begin
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
            end
        end
    end

    // completions are gated by reset so an aborted transaction never reports back
    always_comb begin
        ga              = state == BUSY && !grant && !reset;
        gb              = state == BUSY && grant && !reset;
        bus.a_read_data = bus.mem_read_data;
        bus.b_read_data = bus.mem_read_data;
        bus.a_read_ack  = ga & bus.mem_read_ack;
        bus.a_write_ack = ga & bus.mem_write_ack;
        bus.a_nxm       = ga & (bus.mem_nxm | tmo);
        bus.b_read_ack  = gb & bus.mem_read_ack;
        bus.b_write_ack = gb & bus.mem_write_ack;
        bus.b_nxm       = gb & (bus.mem_nxm | tmo);
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with a transaction-level reference model checked every cycle.
module tb_mem_arb;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   auto_ack = 1'b0;

    mem_arb_if bus();

    mem_arb #(.TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    // Reference model: who owns the memory, how long it has waited, whether a dead cycle is due
    int          m_owner = -1;
    int          m_bc = 0;
    int          m_last = 1;
    bit          m_dead = 1'b0;
    bit          m_rd = 1'b0;
    bit          m_wr = 1'b0;
    logic [21:0] m_addr = '0;
    logic [35:0] m_wd = '0;
    bit          armed = 1'b0;

    always @(negedge clk) begin
        bit resp, to_hit, fwd, ar, br;
        int w;
        logic [137:0] act, exp;
        resp   = bus.mem_read_ack | bus.mem_write_ack | bus.mem_nxm;
        fwd    = m_owner >= 0 && !reset;
        to_hit = fwd && m_bc == TO && !resp;
        exp = {fwd && m_owner == 0 && bus.mem_read_ack, fwd && m_owner == 0 && bus.mem_write_ack,
               fwd && m_owner == 0 && (bus.mem_nxm || to_hit),
               fwd && m_owner == 1 && bus.mem_read_ack, fwd && m_owner == 1 && bus.mem_write_ack,
               fwd && m_owner == 1 && (bus.mem_nxm || to_hit),
               m_rd, m_wr, m_addr, m_wd, bus.mem_read_data, bus.mem_read_data};
        act = {bus.a_read_ack, bus.a_write_ack, bus.a_nxm, bus.b_read_ack, bus.b_write_ack, bus.b_nxm,
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_write_data, bus.a_read_data, bus.b_read_data};
        if (armed) begin
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model @%0t: got %h want %h", $time, act, exp);
            end
        end
        ar = bus.a_read | bus.a_write;
        br = bus.b_read | bus.b_write;
        if (reset) begin
            armed = 1'b1; m_owner = -1; m_bc = 0; m_last = 1; m_dead = 0;
            m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0;
        end else if (m_owner >= 0) begin
            if (resp || to_hit) begin
                m_owner = -1; m_dead = 1; m_rd = 0; m_wr = 0;
            end else
                m_bc++;
        end else if (m_dead)
            m_dead = 0;
        else if (ar || br) begin
`ifdef MEMARB_RR_EN
            w = (ar && br) ? 1 - m_last : (br ? 1 : 0);
`else
            w = ar ? 0 : 1;
`endif
            m_last = w; m_owner = w; m_bc = 1;
            m_addr = w == 1 ? bus.b_addr : bus.a_addr;
            m_wd   = w == 1 ? bus.b_write_data : bus.a_write_data;
            m_wr   = w == 1 ? bus.b_write : bus.a_write;
            m_rd   = w == 1 ? (bus.b_read && !bus.b_write) : (bus.a_read && !bus.a_write);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            bus.mem_read_ack  = bus.mem_read;
            bus.mem_write_ack = bus.mem_write;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int grants[$];
        int n;
        bus.a_addr = '0; bus.a_write_data = '0; bus.a_write = 0; bus.a_read = 0;
        bus.b_addr = '0; bus.b_write_data = '0; bus.b_write = 0; bus.b_read = 0;
        bus.mem_read_data = '0; bus.mem_write_ack = 0; bus.mem_read_ack = 0; bus.mem_nxm = 0;
        cyc(); cyc();
        reset = 0;
        @(negedge clk);
        chk("reset_mem_req", {bus.mem_read, bus.mem_write}, 0);
        chk("reset_addr", bus.mem_addr, 0);
        chk("reset_acks", {bus.a_read_ack, bus.a_nxm, bus.b_write_ack, bus.b_nxm}, 0);

        // A read, acked in the third BUSY cycle
        cyc(); bus.a_addr = 22'o001000; bus.a_read = 1;
        @(negedge clk); chk("t1_pre", bus.mem_read, 0);
        cyc();
        @(negedge clk); chk("t1_req", {bus.mem_read, bus.mem_addr}, {1'b1, 22'o001000});
        cyc(); cyc(); bus.mem_read_ack = 1; bus.mem_read_data = 36'o123456701234;
        @(negedge clk);
        chk("t1_ack", bus.a_read_ack, 1);
        chk("t1_data", bus.a_read_data, 36'o123456701234);
        chk("t1_b_quiet", {bus.b_read_ack, bus.b_write_ack, bus.b_nxm}, 0);
        cyc(); bus.mem_read_ack = 0; bus.a_read = 0;
        @(negedge clk); chk("t1_drop", {bus.mem_read, bus.a_read_ack}, 0);
        cyc(); cyc();

        // B write, acked in the first BUSY cycle
        cyc(); bus.b_addr = 22'o000100; bus.b_write_data = 36'o777777000000; bus.b_write = 1;
        cyc(); bus.mem_write_ack = 1;
        @(negedge clk);
        chk("t2_req", {bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_write_data},
            {2'b10, 22'o000100, 36'o777777000000});
        chk("t2_ack", {bus.b_write_ack, bus.a_write_ack}, 2'b10);
        cyc(); bus.mem_write_ack = 0; bus.b_write = 0;
        @(negedge clk); chk("t2_drop", bus.mem_write, 0);
        cyc(); cyc();

        // both masters request continuously; B asserts read+write, which must act as a write
        auto_ack = 1;
        bus.a_addr = 22'o004000; bus.a_read = 1;
        bus.b_addr = 22'o000200; bus.b_read = 1; bus.b_write = 1;
        for (int i = 0; i < 30 && grants.size() < 4; i++) begin
            cyc();
            @(negedge clk);
            if (bus.a_read_ack) grants.push_back(0);
            if (bus.b_write_ack) grants.push_back(1);
        end
        cyc(); bus.a_read = 0; bus.b_read = 0; bus.b_write = 0;
        auto_ack = 0;
        cyc(); bus.mem_read_ack = 0; bus.mem_write_ack = 0;
        cyc();
        chk("t3_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEMARB_RR_EN
            chk($sformatf("t3_grant%0d", i), i < grants.size() ? grants[i] : -1, i % 2);
`else
            chk($sformatf("t3_grant%0d", i), i < grants.size() ? grants[i] : -1, 0);
`endif
        end

        // timeout: no memory response
        cyc(); bus.a_addr = 22'o002000; bus.a_read = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            @(negedge clk);
            if (bus.mem_read) n++;
            if (bus.a_nxm) break;
        end
        chk("t4_nxm", bus.a_nxm, 1);
        chk("t4_cycles", n, TO);
        cyc(); bus.a_read = 0; bus.b_addr = 22'o000300; bus.b_write = 1;
        @(negedge clk); chk("t4_pulse", {bus.a_nxm, bus.mem_read}, 0);
        cyc();
        @(negedge clk); chk("t4_idle", bus.mem_write, 0);
        cyc();
        @(negedge clk); chk("t4_next", bus.mem_write, 1);
        cyc(); bus.mem_write_ack = 1;
        cyc(); bus.mem_write_ack = 0; bus.b_write = 0;
        cyc(); cyc();

        // ack in the expiry cycle beats the timeout
        cyc(); bus.a_read = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.mem_read) n++;
            if (n == TO) begin bus.mem_read_ack = 1; break; end
        end
        @(negedge clk); chk("t5_ack_wins", {bus.a_read_ack, bus.a_nxm}, 2'b10);
        cyc(); bus.mem_read_ack = 0; bus.a_read = 0;
        cyc(); cyc();

        // nxm and ack together are both forwarded
        cyc(); bus.b_addr = 22'o000400; bus.b_read = 1;
        cyc(); bus.mem_nxm = 1; bus.mem_read_ack = 1;
        @(negedge clk); chk("t6_both", {bus.b_nxm, bus.b_read_ack, bus.a_read_ack, bus.a_nxm}, 4'b1100);
        cyc(); bus.mem_nxm = 0; bus.mem_read_ack = 0; bus.b_read = 0;
        cyc(); cyc();

        // mem pulses while IDLE are dropped
        cyc(); bus.mem_write_ack = 1; bus.mem_read_ack = 1; bus.mem_nxm = 1;
        @(negedge clk);
        chk("t7_idle_ack", {bus.a_write_ack, bus.b_write_ack, bus.a_read_ack, bus.b_read_ack, bus.a_nxm, bus.b_nxm}, 0);
        cyc(); bus.mem_write_ack = 0; bus.mem_read_ack = 0; bus.mem_nxm = 0;

        // reset during BUSY aborts without forwarding the coincident ack
        cyc(); bus.a_addr = 22'o003000; bus.a_read = 1;
        cyc();
        @(negedge clk); chk("t8_busy", bus.mem_read, 1);
        cyc(); reset = 1; bus.mem_read_ack = 1; bus.a_read = 0;
        @(negedge clk); chk("t8_no_ack", bus.a_read_ack, 0);
        cyc(); reset = 0; bus.mem_read_ack = 0;
        @(negedge clk); chk("t8_abort", {bus.mem_read, bus.mem_write}, 0);
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
# mem_arb

Two-port memory arbiter between the paging/cache side and a second master (DMA or front-end) in front of the single `mem` port. It uses the same read/write/ack/nxm handshake as the rest of the memory path. It serialises requests, routes acknowledgements and NXM to the granted master, and generates NXM itself when memory fails to answer within a bounded time.

## Interface
Parameters:
- TIMEOUT, 64: cycles in BUSY without ack/nxm before the arbiter signals NXM; 0 disables the timeout.

Ports (widths: `PADDR = 22, `WORD = 36):
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- a_addr  in  `PADDR  master A (pag/cache side) address
- a_write_data  in  `WORD  master A write data
- a_write, a_read  in  1 each  master A request levels
- a_read_data  out  `WORD  read data to A
- a_write_ack, a_read_ack, a_nxm  out  1 each  completion pulses to A
- b_addr, b_write_data, b_write, b_read  in  as for A  master B (DMA)
- b_read_data, b_write_ack, b_read_ack, b_nxm  out  as for A  completion to B
- mem_addr  out  `PADDR  registered address to mem
- mem_write_data  out  `WORD  registered write data to mem
- mem_write, mem_read  out  1 each  registered request to mem
- mem_read_data  in  `WORD  mem read data
- mem_write_ack, mem_read_ack, mem_nxm  in  1 each  mem completion pulses

## Operation
- Handshake contract:
  - Each master holds its request level, address and data stable until it sees an ack or nxm pulse.
  - Each master drops its request on the following edge.
  - A master asserting read and write together is treated as a write only.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any request is pending, the winner is latched into `grant`.
  - mem_addr, mem_write_data, mem_read and mem_write are loaded from the winner; the next state is BUSY.
  - With no request, the state stays IDLE and mem outputs stay 0.
- BUSY:
  - Mem outputs are held.
  - mem_read_ack, mem_write_ack and mem_nxm are forwarded combinationally to the granted master only, in the same cycle they arrive.
  - Any of these pulses takes the state to DONE and clears mem_read/mem_write on that edge.
- Timeout:
  - The timeout counter counts BUSY cycles.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no mem response, the arbiter pulses the granted master's nxm for that cycle, clears the mem request and goes to DONE.
- DONE: one dead cycle for the master to drop its request; requests are ignored; the next state is IDLE.
- a_read_data and b_read_data are both driven from mem_read_data (broadcast). They are meaningful only with the matching read_ack.
- Mem ack/nxm pulses arriving in IDLE or DONE are ignored and not forwarded.
- Arbitration is fixed priority A over B, or round-robin per Configuration.
- mem_addr and mem_write_data hold their last value between transactions.

## Timing
- Reset values:
  - Outputs: all request/ack/nxm outputs 0; mem_addr 0; mem_write_data 0.
  - Internal state: state IDLE; timeout counter 0; last-grant = B.
- Reset asserted mid-transaction aborts it: mem request drops on that edge and no ack is forwarded.
- Latency:
  - Request sampled in IDLE at edge N; mem request visible in cycle N+1.
  - Ack in cycle T reaches the master in cycle T.
  - IDLE is re-entered at T+2; the earliest next mem request is cycle T+3.
- Minimum transaction spacing is 3 cycles plus memory latency.
- Timeout: with no response, NXM appears in the TIMEOUT-th BUSY cycle.
- Simultaneous mem ack and timeout expiry: the ack wins and the arbiter NXM is suppressed.
- Simultaneous mem_nxm and mem ack: both are forwarded as received.

## Configuration
- MEMARB_RR_EN defined: round-robin.
  - When both masters request in IDLE, the master not granted last wins.
  - Last-grant updates on every grant.
- MEMARB_RR_EN undefined: fixed priority; A always wins ties and B can be starved while A requests continuously.

## Test plan
- Reset, then A read 22'o001000; mem acks 3 cycles later with 36'o123456701234 -> mem_read high from cycle 1, a_read_ack and a_read_data correct in ack cycle, b_* outputs 0, mem_read low next cycle.
- B write 22'o000100 data 36'o777777000000 -> mem_write with those values one cycle after request, b_write_ack on mem ack, a_write_ack stays 0.
- A and B both request continuously, mem acks in 1 cycle:
  - With MEMARB_RR_EN: grants alternate A,B,A,B.
  - Without it: only A is served and B's request stays pending.
- TIMEOUT=8, A read with no mem response -> a_nxm one-cycle pulse in the 8th BUSY cycle, mem_read cleared, state back to IDLE two cycles later.
- mem_write_ack pulsed while IDLE with no grant -> no ack on either master. Reset asserted during BUSY -> mem_read/mem_write 0 next cycle and no ack forwarded.
